// File: rtl/irq_pkg.sv
// irq_pkg: shared source indices, handler vectors, FSM states and priority helpers for the IRQ controller.
package irq_pkg;
    localparam int NSRC = 4;
    localparam logic [1:0] SRC_TIMER = 2'd0, SRC_SYSCALL = 2'd1, SRC_PORT = 2'd2, SRC_EXCEPT = 2'd3;
    localparam logic [9:0] VEC_TIMER = 10'h013, VEC_SYSCALL = 10'h3FD, VEC_PORT = 10'h3FC, VEC_EXCEPT = 10'h3FB;
    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;
    // Fixed priority order: except > port > timer > syscall.
    function automatic logic [1:0] prio_idx(input logic [NSRC-1:0] r);
        return r[SRC_EXCEPT] ? SRC_EXCEPT : r[SRC_PORT] ? SRC_PORT : r[SRC_TIMER] ? SRC_TIMER : SRC_SYSCALL;
    endfunction
    function automatic logic [1:0] prio_rank(input logic [1:0] idx);
        return idx == SRC_EXCEPT ? 2'd3 : idx == SRC_PORT ? 2'd2 : idx == SRC_TIMER ? 2'd1 : 2'd0;
    endfunction
    function automatic logic [9:0] vec_of(input logic [1:0] idx);
        return idx == SRC_EXCEPT ? VEC_EXCEPT : idx == SRC_PORT ? VEC_PORT : idx == SRC_TIMER ? VEC_TIMER : VEC_SYSCALL;
    endfunction
endpackage

// File: rtl/irq_if.sv
// irq_if: CPU-side and source-side signals of the IRQ controller; master drives requests/strobes, slave is the controller.
interface irq_if;
    logic [3:0] irq_req;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       cpu_ack;
    logic       iret;
    logic       irq_pending;
    logic [9:0] vec_addr;
    logic [3:0] in_service;
    logic [3:0] mask_q;
    modport master(output irq_req, mask_we, mask_wdata, cpu_ack, iret,
                   input irq_pending, vec_addr, in_service, mask_q);
    modport slave(input irq_req, mask_we, mask_wdata, cpu_ack, iret,
                  output irq_pending, vec_addr, in_service, mask_q);
endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder returning valid, winning index and its vector.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NSRC-1:0] req_i,
    output logic            valid_o,
    output logic [1:0]      idx_o,
    output logic [9:0]      vec_o
);
    assign valid_o = |req_i;
    assign idx_o   = prio_idx(req_i);
    assign vec_o   = valid_o ? vec_of(idx_o) : '0;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-detecting 4-source interrupt controller with mask, fixed priority and IDLE/REQUEST/SERVICE FSM.
// Optional nesting of strictly higher-priority sources is enabled by defining IRQ_NESTING_EN.
module irq_controller
    import irq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    irq_if.slave bus
);
    state_t state_q, state_d;
    logic [NSRC-1:0] prev_q, arm_q, pend_q, pend_d, svc_q, svc_d, en_mask_q;
    logic [NSRC-1:0] edges, eligible, win_oh, top_oh;
    logic [1:0] win_q, win_d, el_idx;
    logic [9:0] vec_q, vec_d, el_vec;
    logic el_valid, can_raise;
    // A source held high through reset stays disarmed until it has been seen low.
    assign edges    = bus.irq_req & ~prev_q & arm_q;
    assign eligible = pend_q & en_mask_q & ~svc_q;
    assign win_oh   = 4'b1 << win_q;
    assign top_oh   = 4'b1 << prio_idx(svc_q);
    irq_prio_enc u_enc (.req_i(eligible), .valid_o(el_valid), .idx_o(el_idx), .vec_o(el_vec));
`ifdef IRQ_NESTING_EN
    assign can_raise = el_valid && (svc_q == '0 || prio_rank(el_idx) > prio_rank(prio_idx(svc_q)));
`else
    assign can_raise = el_valid && svc_q == '0;
`endif
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | edges;
        svc_d   = svc_q;
        win_d   = win_q;
        vec_d   = vec_q;
        unique case (state_q)
            REQUEST: if (bus.cpu_ack) begin
                pend_d  = (pend_q & ~win_oh) | edges;
                svc_d   = svc_q | win_oh;
                state_d = SERVICE;
            end
            SERVICE: if (bus.iret) begin
                svc_d   = svc_q & ~top_oh;
                state_d = (svc_q & ~top_oh) == '0 ? IDLE : SERVICE;
            end else if (can_raise) begin
                state_d = REQUEST;
                win_d   = el_idx;
                vec_d   = el_vec;
            end
            default: if (can_raise) begin
                state_d = REQUEST;
                win_d   = el_idx;
                vec_d   = el_vec;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            arm_q     <= ~bus.irq_req;
            pend_q    <= '0;
            svc_q     <= '0;
            en_mask_q <= 4'b1111;
            win_q     <= '0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= bus.irq_req;
            arm_q     <= arm_q | ~bus.irq_req;
            pend_q    <= pend_d;
            svc_q     <= svc_d;
            en_mask_q <= bus.mask_we ? bus.mask_wdata : en_mask_q;
            win_q     <= win_d;
            vec_q     <= vec_d;
        end
    end
    assign bus.irq_pending = state_q == REQUEST;
    assign bus.vec_addr    = state_q == REQUEST ? vec_q : '0;
    assign bus.in_service  = svc_q;
    assign bus.mask_q      = en_mask_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed + random stimulus against a transaction-level model; a monitor pops expected status/vectors.
module tb_irq_controller;
    logic clk = 1'b0;
    logic reset;
    irq_if bus();
    irq_controller dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pend;
        logic [9:0] vec;
        logic [3:0] svc;
        logic [3:0] mask;
    } status_t;
    status_t    sq[$];
    logic [9:0] vq[$];
    int checks = 0;
    int errors = 0;

    bit [3:0] m_prev, m_arm, m_pend, m_svc, m_mask;
    bit       m_req;
    int       m_src;
    int       order[4] = '{3, 2, 0, 1};

    function automatic int best(input bit [3:0] s);
        for (int k = 0; k < 4; k++) if (s[order[k]]) return order[k];
        return -1;
    endfunction
    function automatic int rank(input int s);
        for (int k = 0; k < 4; k++) if (order[k] == s) return 3 - k;
        return -1;
    endfunction
    function automatic logic [9:0] vec(input int s);
        return s == 0 ? 10'h013 : s == 3 ? 10'h3FB : s == 2 ? 10'h3FC : 10'h3FD;
    endfunction

    task automatic step(input logic [3:0] r, input logic mwe, input logic [3:0] mwd,
                        input logic a, input logic i, input logic rs);
        bit [3:0] edg, np;
        int c;
        bit raise;
        status_t st;
        bus.irq_req = r; bus.mask_we = mwe; bus.mask_wdata = mwd;
        bus.cpu_ack = a; bus.iret = i; reset = rs;
        if (rs) begin
            m_prev = 0; m_arm = ~r; m_pend = 0; m_svc = 0; m_mask = 4'hF; m_req = 0;
        end else begin
            edg = r & ~m_prev & m_arm;
            c = best(m_pend & m_mask & ~m_svc);
`ifdef IRQ_NESTING_EN
            raise = !m_req && c >= 0 && !(i && m_svc != 0) && (m_svc == 0 || rank(c) > rank(best(m_svc)));
`else
            raise = !m_req && c >= 0 && m_svc == 0;
`endif
            np = m_pend;
            if (m_req && a) begin
                np[m_src] = 0;
                m_svc[m_src] = 1;
                m_req = 0;
            end else if (!m_req && m_svc != 0 && i) begin
                m_svc[best(m_svc)] = 0;
            end
            if (raise) begin
                m_req = 1;
                m_src = c;
                vq.push_back(vec(c));
            end
            m_pend = np | edg;
            if (mwe) m_mask = mwd;
            m_prev = r;
            m_arm |= ~r;
        end
        st.pend = m_req;
        st.vec  = m_req ? vec(m_src) : 10'h0;
        st.svc  = m_svc;
        st.mask = m_mask;
        sq.push_back(st);
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] r, input int n, input bit aa, input bit ai);
        repeat (n) step(r, 1'b0, 4'h0, aa && m_req, ai && !m_req && m_svc != 0, 1'b0);
    endtask

    initial begin
        logic prev_p;
        status_t e;
        logic [9:0] v;
        prev_p = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                checks++;
                if (bus.irq_pending !== e.pend || bus.vec_addr !== e.vec || bus.in_service !== e.svc || bus.mask_q !== e.mask) begin
                    errors++;
                    $display("FAIL status t=%0t got pend=%b vec=%h svc=%b mask=%b exp pend=%b vec=%h svc=%b mask=%b",
                             $time, bus.irq_pending, bus.vec_addr, bus.in_service, bus.mask_q, e.pend, e.vec, e.svc, e.mask);
                end
            end
            if (bus.irq_pending === 1'b1 && !prev_p) begin
                checks++;
                if (vq.size() == 0) begin
                    errors++;
                    $display("FAIL vector t=%0t got unexpected request vec=%h exp none", $time, bus.vec_addr);
                end else begin
                    v = vq.pop_front();
                    if (bus.vec_addr !== v) begin
                        errors++;
                        $display("FAIL vector t=%0t got %h exp %h", $time, bus.vec_addr, v);
                    end
                end
            end
            prev_p = bus.irq_pending === 1'b1;
        end
    end

    initial begin
        logic [3:0] r;
        step(4'h0, 0, 4'h0, 0, 0, 1);
        step(4'h0, 0, 4'h0, 0, 0, 1);
        run(4'b0001, 3, 0, 0);
        run(4'b0001, 2, 1, 0);
        run(4'b0001, 2, 0, 1);
        run(4'b0000, 2, 0, 0);
        run(4'b1101, 16, 1, 1);
        run(4'b0000, 2, 0, 0);
        step(4'h0, 1, 4'b1110, 0, 0, 0);
        run(4'b0001, 4, 1, 1);
        step(4'b0001, 1, 4'b1111, 0, 0, 0);
        run(4'b0001, 6, 1, 1);
        run(4'b0000, 2, 0, 0);
        run(4'b0001, 4, 1, 0);
        run(4'b1001, 5, 1, 0);
        run(4'b1001, 8, 1, 1);
        run(4'b0000, 2, 0, 0);
        run(4'b0100, 5, 1, 0);
        step(4'b0100, 0, 4'h0, 0, 0, 1);
        run(4'b0100, 4, 1, 1);
        run(4'b0000, 2, 1, 1);
        run(4'b0100, 6, 1, 1);
        run(4'b0000, 2, 0, 0);
        step(4'h0, 0, 4'h0, 1, 0, 0);
        run(4'b0010, 3, 0, 0);
        step(4'b0010, 0, 4'h0, 0, 1, 0);
        run(4'b0010, 5, 1, 1);
        r = 4'h0;
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            step(r, $urandom_range(0, 19) == 0, 4'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 4, $urandom_range(0, 199) == 0);
        end
        @(posedge clk);
        #3;
        checks++;
        if (sq.size() != 0 || vq.size() != 0) begin
            errors++;
            $display("FAIL drain got status=%0d vectors=%0d left exp 0 0", sq.size(), vq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
